seri_cikarici: RTL and testbench
================================

# seri_cikarici

Bit-serial N-bit subtractor computing `fark = sayi1 - sayi2` (two's complement), one bit per clock, LSB first. It is the sequential counterpart of the combinational ripple adder in the arithmetic library. It trades latency (N cycles) for a single full-subtractor cell and a borrow flip-flop. It sits behind a start/done handshake so a controller can issue operations back-to-back.

## Interface
Parameters:
- `N`, default 64: operand and result width in bits; legal range N ≥ 1.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `basla`, input, 1: start request. Sampled only when `mesgul` = 0.
- `sayi1`, input, N: minuend. Captured on the edge that accepts `basla`.
- `sayi2`, input, N: subtrahend. Captured on the edge that accepts `basla`.
- `mesgul`, output, 1: high while a subtraction is in progress (state RUN).
- `bitti`, output, 1: one-cycle pulse; result outputs are updated in the same cycle.
- `fark`, output, N: result `(sayi1 - sayi2) mod 2^N`. Holds its value until the next completion.
- `odunc`, output, 1: final borrow; 1 when `sayi1 < sayi2` unsigned.
- `tasma`, output, 1: signed overflow of the subtraction.

## Operation
- Internal state:
  - Shift registers `a_sr` and `b_sr` (N bits each).
  - Result shift register `r_sr` (N bits).
  - Borrow flip-flop `br`.
  - Bit counter `cnt`, width `$clog2(N)` (minimum 1).
  - Captured sign bits `a_msb` and `b_msb`.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If `basla` = 1, load `a_sr` ← `sayi1`, `b_sr` ← `sayi2`, `br` ← 0, `cnt` ← 0, and capture both MSBs.
  - Then go to RUN. Otherwise stay in IDLE.
- RUN, on each edge:
  - `d = a_sr[0] ^ b_sr[0] ^ br`
  - `br ← (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br)`
  - Shift `a_sr` and `b_sr` right by one.
  - Shift `d` into `r_sr` at the MSB (`r_sr ← {d, r_sr[N-1:1]}`).
  - `cnt ← cnt + 1`.
- RUN exit: on the edge where `cnt == N-1`, go to DONE. On that same edge:
  - `fark ← {d, r_sr[N-1:1]}`
  - `odunc ← ` the borrow-out computed this edge
  - `tasma ← (a_msb != b_msb) & (d != a_msb)`, where `d` is the final (MSB) difference bit.
- DONE:
  - `bitti` = 1 for exactly this cycle.
  - If `basla` = 1, accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `basla` while in RUN is ignored. It is not queued.
- `sayi1`/`sayi2` changes after acceptance have no effect on the running operation.
- N = 1: RUN lasts one edge. Result is the single-bit difference; `tasma` follows the same formula.

## Timing
- Reset (`rst_n` = 0, asynchronous, at any time including mid-RUN):
  - State → IDLE.
  - `mesgul` = 0, `bitti` = 0, `fark` = 0, `odunc` = 0, `tasma` = 0.
  - All internal registers cleared; an in-flight operation is discarded.
- Latency: `basla` is accepted on edge E0.
  - `mesgul` is high from after E0 to after E(N).
  - `fark`, `odunc`, `tasma` update and `bitti` rises on edge E(N).
  - `bitti` falls after E(N+1).
- Throughput: one result per N+1 cycles when `basla` is held high (the DONE cycle re-accepts).
- `bitti` and `mesgul` are never both high.
- All outputs are driven by registers; there are no combinational input-to-output paths.

## Test plan
All scenarios use N = 8.
- Basic: `sayi1` = 0x05, `sayi2` = 0x03, 1-cycle `basla` → `bitti` 8 edges after acceptance; `fark` = 0x02, `odunc` = 0, `tasma` = 0.
- Borrow: 0x03 - 0x05 → `fark` = 0xFE, `odunc` = 1, `tasma` = 0. Also 0x00 - 0x01 → 0xFF, `odunc` = 1.
- Signed overflow: 0x80 - 0x01 → `fark` = 0x7F, `odunc` = 0, `tasma` = 1. Also 0x7F - 0xFF → 0x80, `odunc` = 1, `tasma` = 1.
- Busy and operand protection:
  - Pulse `basla` with 0x10/0x20 in RUN cycle 3 → ignored.
  - Change `sayi1`/`sayi2` mid-RUN → result still from the captured operands.
  - Exactly one `bitti` pulse.
- Back-to-back with `basla` held high: 0x09 - 0x04, then 0x04 - 0x09 → `bitti` pulses 9 cycles apart; results 0x05 then 0xFB with `odunc` = 1.
- Reset mid-operation: assert `rst_n` = 0 in RUN cycle 4 → all outputs 0 immediately and no `bitti`. After release, a new 0xAA - 0x55 → 0x55, `odunc` = 0, `tasma` = 1.
- Random: 1000 random operand pairs checked against a reference model for `fark` = (a - b) mod 256, `odunc` = (a < b), and signed overflow.

Source files
------------

// File: rtl/seri_cikarici.sv
// Bit-serial N-bit two's-complement subtractor (fark = sayi1 - sayi2), LSB first,
// one full-subtractor cell plus a borrow flip-flop behind a basla/bitti handshake.
module seri_cikarici #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         basla,
    input  logic [N-1:0] sayi1,
    input  logic [N-1:0] sayi2,
    output logic         mesgul,
    output logic         bitti,
    output logic [N-1:0] fark,
    output logic         odunc,
    output logic         tasma
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_sr, b_sr, r_sr, r_nx;
    logic [CW-1:0]  cnt;
    logic           br, br_nx, d;
    logic           a_msb, b_msb;
    logic           load, last;

    always_comb begin
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        last     = (state == RUN) && (cnt == CW'(N - 1));
        load     = (state != RUN) && basla;
        state_nx = state;
        unique case (state)
            IDLE:    if (basla) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = basla ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A 1-bit result register has nothing to shift; the slice form would be empty.
    generate
        if (N == 1) begin : g_r_one
            always_comb r_nx = d;
        end else begin : g_r_wide
            always_comb r_nx = {d, r_sr[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            fark  <= '0;
            odunc <= 1'b0;
            tasma <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_sr  <= sayi1;
                b_sr  <= sayi2;
                br    <= 1'b0;
                cnt   <= '0;
                a_msb <= sayi1[N-1];
                b_msb <= sayi2[N-1];
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_nx;
                br   <= br_nx;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    fark  <= r_nx;
                    odunc <= br_nx;
                    tasma <= (a_msb != b_msb) && (d != a_msb);
                end
            end
        end
    end

    assign mesgul = (state == RUN);
    assign bitti  = (state == DONE);

endmodule

// File: tb/tb_seri_cikarici.sv
// Self-checking bench for seri_cikarici at N = 8: directed cases plus random
// operands compared against an arithmetic reference model.
module tb_seri_cikarici;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         basla;
    logic [N-1:0] sayi1, sayi2;
    logic         mesgul, bitti, odunc, tasma;
    logic [N-1:0] fark;

    int n_checks = 0;
    int n_fail   = 0;

    seri_cikarici #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .basla(basla), .sayi1(sayi1), .sayi2(sayi2),
        .mesgul(mesgul), .bitti(bitti), .fark(fark), .odunc(odunc), .tasma(tasma)
    );

    always #5 clk = ~clk;

    // {tasma, odunc, fark} from plain integer arithmetic
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa, sb, full;
        logic [N-1:0] f;
        logic bo, ov;
        sa   = (a >= 128) ? int'(a) - 256 : int'(a);
        sb   = (b >= 128) ? int'(b) - 256 : int'(b);
        full = sa - sb;
        f    = N'((int'(a) - int'(b) + 256) % 256);
        bo   = (a < b);
        ov   = (full > 127) || (full < -128);
        return {ov, bo, f};
    endfunction

    // Drive basla for one cycle; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        basla = 1'b1; sayi1 = a; sayi2 = b;
        @(negedge clk);
        basla = 1'b0;
    endtask

    // Count negedges until bitti is seen (bounded).
    task automatic wait_done(output int k);
        k = 0;
        while (bitti !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; basla = 1'b0; sayi1 = '0; sayi2 = '0;
        repeat (3) @(negedge clk);
        n_checks++; if ({mesgul, bitti, odunc, tasma} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {mesgul, bitti, odunc, tasma}); end
        n_checks++; if (fark !== 8'h00) begin n_fail++;
            $display("FAIL reset_fark: got %h expected 00", fark); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({mesgul, bitti} !== 2'b00) begin n_fail++;
            $display("FAIL idle_after_reset: got %b expected 00", {mesgul, bitti}); end
    endtask

    task automatic test_directed;
        logic [7:0] ta [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
        logic [7:0] tb [5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'hFF};
        logic [7:0] tf [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
        logic       to [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       tt [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int k;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb[i]);
            n_checks++; if (mesgul !== 1'b1) begin n_fail++;
                $display("FAIL dir%0d_busy: got %b expected 1", i, mesgul); end
            wait_done(k);
            n_checks++; if (k != 8) begin n_fail++;
                $display("FAIL dir%0d_latency: got %0d expected 8", i, k); end
            n_checks++; if ({tt[i], to[i], tf[i]} !== {tasma, odunc, fark}) begin n_fail++;
                $display("FAIL dir%0d_result: got t=%b o=%b f=%h expected t=%b o=%b f=%h",
                         i, tasma, odunc, fark, tt[i], to[i], tf[i]); end
            @(negedge clk);
            n_checks++; if (bitti !== 1'b0) begin n_fail++;
                $display("FAIL dir%0d_pulse_width: got %b expected 0", i, bitti); end
        end
    endtask

    task automatic test_busy;
        int k, pulses;
        issue(8'h33, 8'h11);
        repeat (2) @(negedge clk);
        basla = 1'b1; sayi1 = 8'h10; sayi2 = 8'h20;
        @(negedge clk);
        basla = 1'b0; sayi1 = 8'hC3; sayi2 = 8'h5A;
        wait_done(k);
        n_checks++; if (fark !== 8'h22 || odunc !== 1'b0 || tasma !== 1'b0) begin n_fail++;
            $display("FAIL busy_result: got f=%h o=%b t=%b expected f=22 o=0 t=0", fark, odunc, tasma); end
        pulses = 0;
        repeat (12) begin @(negedge clk); if (bitti === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++;
            $display("FAIL busy_extra_bitti: got %0d expected 0", pulses); end
    endtask

    task automatic test_back_to_back;
        int k;
        basla = 1'b1; sayi1 = 8'h09; sayi2 = 8'h04;
        @(negedge clk);
        sayi1 = 8'h04; sayi2 = 8'h09;
        wait_done(k);
        n_checks++; if (k != 8 || fark !== 8'h05 || odunc !== 1'b0) begin n_fail++;
            $display("FAIL b2b_first: got k=%0d f=%h o=%b expected k=8 f=05 o=0", k, fark, odunc); end
        @(negedge clk);
        basla = 1'b0;
        n_checks++; if (mesgul !== 1'b1 || bitti !== 1'b0) begin n_fail++;
            $display("FAIL b2b_reaccept: got mesgul=%b bitti=%b expected 1 0", mesgul, bitti); end
        wait_done(k);
        n_checks++; if (k + 1 != 9) begin n_fail++;
            $display("FAIL b2b_spacing: got %0d expected 9", k + 1); end
        n_checks++; if (fark !== 8'hFB || odunc !== 1'b1 || tasma !== 1'b0) begin n_fail++;
            $display("FAIL b2b_second: got f=%h o=%b t=%b expected f=FB o=1 t=0", fark, odunc, tasma); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k, pulses;
        issue(8'h12, 8'h34);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({mesgul, bitti, odunc, tasma} !== 4'b0 || fark !== 8'h00) begin n_fail++;
            $display("FAIL midreset_outputs: got m=%b b=%b o=%b t=%b f=%h expected all 0",
                     mesgul, bitti, odunc, tasma, fark); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin @(negedge clk); if (bitti === 1'b1 || mesgul === 1'b1) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++;
            $display("FAIL midreset_discard: got %0d active cycles expected 0", pulses); end
        issue(8'hAA, 8'h55);
        wait_done(k);
        n_checks++; if (k != 8 || fark !== 8'h55 || odunc !== 1'b0 || tasma !== 1'b1) begin n_fail++;
            $display("FAIL midreset_new_op: got k=%0d f=%h o=%b t=%b expected k=8 f=55 o=0 t=1",
                     k, fark, odunc, tasma); end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        logic [N+1:0] exp_v;
        int k, both;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            exp_v = model(a, b);
            issue(a, b);
            sayi1 = N'($urandom); sayi2 = N'($urandom);
            k = 0; both = 0;
            while (bitti !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
                if (bitti === 1'b1 && mesgul === 1'b1) both++;
            end
            n_checks++; if (k != 8 || both != 0) begin n_fail++;
                $display("FAIL rnd%0d_timing: got k=%0d overlap=%0d expected k=8 overlap=0", i, k, both); end
            n_checks++; if ({tasma, odunc, fark} !== exp_v) begin n_fail++;
                $display("FAIL rnd%0d_result: a=%h b=%h got t=%b o=%b f=%h expected t=%b o=%b f=%h",
                         i, a, b, tasma, odunc, fark, exp_v[N+1], exp_v[N], exp_v[N-1:0]); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
